// File: rtl/isp_pkg.sv
`default_nettype none
// ============================================================================
// Package  : isp_pkg
// Brief    : Shared widths and FSM encoding for the binary bounding-box stage.
// Revision : 1.0
// ============================================================================
package isp_pkg;

    localparam int c_H_W_DEF        = 11;
    localparam int c_V_W_DEF        = 11;
    localparam int c_CNT_W_DEF      = 21;
    localparam int c_MIN_PIXELS_DEF = 64;

    typedef logic [1:0] bbox_state_t;

    localparam bbox_state_t c_ST_WAIT_FRAME = 2'd0;
    localparam bbox_state_t c_ST_ACTIVE     = 2'd1;
    localparam bbox_state_t c_ST_LATCH      = 2'd2;

endpackage
`default_nettype wire

// File: rtl/binary_bbox_stat_if.sv
`default_nettype none
// ============================================================================
// Interface : binary_bbox_stat_if
// Brief     : Observed binary pixel stream plus per-frame bounding-box results.
// Revision  : 1.0
// ============================================================================
interface binary_bbox_stat_if
    import isp_pkg::*;
#(
    parameter int H_W   = c_H_W_DEF,
    parameter int V_W   = c_V_W_DEF,
    parameter int CNT_W = c_CNT_W_DEF
);
    logic             i_vsync;
    logic             i_href;
    logic             i_clken;
    logic             i_bit;
    logic [H_W-1:0]   o_x_min;
    logic [H_W-1:0]   o_x_max;
    logic [V_W-1:0]   o_y_min;
    logic [V_W-1:0]   o_y_max;
    logic [CNT_W-1:0] o_pix_cnt;
    logic             o_found;
    logic             o_valid;

    modport master (
        output i_vsync, i_href, i_clken, i_bit,
        input  o_x_min, o_x_max, o_y_min, o_y_max, o_pix_cnt, o_found, o_valid
    );

    modport slave (
        input  i_vsync, i_href, i_clken, i_bit,
        output o_x_min, o_x_max, o_y_min, o_y_max, o_pix_cnt, o_found, o_valid
    );

endinterface
`default_nettype wire

// File: rtl/binary_bbox_stat_sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_det
// Brief    : Registers a sync signal and flags its rising and falling edges.
// Revision : 1.0
// ============================================================================
module sync_edge_det (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_sig,
    output logic      o_rise,
    output logic      o_fall
);

    logic r_sig_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig_d <= 1'b0;
        end else begin
            r_sig_d <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_sig_d;
    assign o_fall = ~i_sig & r_sig_d;

endmodule
`default_nettype wire

// File: rtl/binary_bbox_stat.sv
`default_nettype none
// ============================================================================
// Module   : binary_bbox_stat
// Brief    : Per-frame foreground bounding box and pixel count of a binary stream.
// Revision : 1.0
// ============================================================================
module binary_bbox_stat
    import isp_pkg::*;
#(
    parameter int H_W        = c_H_W_DEF,
    parameter int V_W        = c_V_W_DEF,
    parameter int CNT_W      = c_CNT_W_DEF,
    parameter int MIN_PIXELS = c_MIN_PIXELS_DEF
)(
    input  wire logic         pixelclk,
    input  wire logic         rst,
    binary_bbox_stat_if.slave bus
);

    localparam logic [H_W-1:0]   c_X_ALL   = {H_W{1'b1}};
    localparam logic [V_W-1:0]   c_Y_ALL   = {V_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ALL = {CNT_W{1'b1}};

    bbox_state_t      r_state;
    logic [H_W-1:0]   r_x_cnt;
    logic [V_W-1:0]   r_y_cnt;
    logic             r_line_has_pix;
    logic [H_W-1:0]   r_x_min;
    logic [H_W-1:0]   r_x_max;
    logic [V_W-1:0]   r_y_min;
    logic [V_W-1:0]   r_y_max;
    logic [CNT_W-1:0] r_count;

    logic [H_W-1:0]   r_out_x_min;
    logic [H_W-1:0]   r_out_x_max;
    logic [V_W-1:0]   r_out_y_min;
    logic [V_W-1:0]   r_out_y_max;
    logic [CNT_W-1:0] r_out_cnt;
    logic             r_out_found;
    logic             r_out_valid;

    logic w_vs_rise;
    logic w_vs_fall;
    logic w_line_end;
    logic w_href_rise;
    logic w_unused_edges;
    logic w_active;
    logic w_fg;
    logic w_acc_clear;
    logic w_found;

    sync_edge_det u_vsync_edge (
        .clk    (pixelclk),
        .rst    (rst),
        .i_sig  (bus.i_vsync),
        .o_rise (w_vs_rise),
        .o_fall (w_vs_fall)
    );

    sync_edge_det u_href_edge (
        .clk    (pixelclk),
        .rst    (rst),
        .i_sig  (bus.i_href),
        .o_rise (w_href_rise),
        .o_fall (w_line_end)
    );

    assign w_unused_edges = w_vs_fall ^ w_href_rise;

    assign w_active    = (r_state == c_ST_ACTIVE);
    assign w_fg        = w_active & bus.i_clken & bus.i_bit;
    assign w_acc_clear = ((r_state == c_ST_WAIT_FRAME) & w_vs_rise) | (r_state == c_ST_LATCH);
    assign w_found     = (r_count >= CNT_W'(MIN_PIXELS));

    always_ff @(posedge pixelclk) begin
        if (rst) begin
            r_state <= c_ST_WAIT_FRAME;
        end else begin
            case (r_state)
                c_ST_WAIT_FRAME: if (w_vs_rise) r_state <= c_ST_ACTIVE;
                c_ST_ACTIVE:     if (w_vs_rise) r_state <= c_ST_LATCH;
                c_ST_LATCH:      r_state <= c_ST_ACTIVE;
                default:         r_state <= c_ST_WAIT_FRAME;
            endcase
        end
    end

    // A pixel arriving with the line-end edge still uses the old column, then the column clears.
    always_ff @(posedge pixelclk) begin
        if (rst) begin
            r_x_cnt        <= '0;
            r_y_cnt        <= '0;
            r_line_has_pix <= 1'b0;
        end else if (w_vs_rise) begin
            r_x_cnt        <= '0;
            r_y_cnt        <= '0;
            r_line_has_pix <= 1'b0;
        end else if (w_active) begin
            if (w_line_end) begin
                r_x_cnt        <= '0;
                r_line_has_pix <= 1'b0;
                if ((r_line_has_pix | bus.i_clken) && (r_y_cnt != c_Y_ALL)) begin
                    r_y_cnt <= r_y_cnt + V_W'(1);
                end
            end else if (bus.i_clken) begin
                r_line_has_pix <= 1'b1;
                if (r_x_cnt != c_X_ALL) begin
                    r_x_cnt <= r_x_cnt + H_W'(1);
                end
            end
        end
    end

    always_ff @(posedge pixelclk) begin
        if (rst || w_acc_clear) begin
            r_x_min <= c_X_ALL;
            r_x_max <= '0;
            r_y_min <= c_Y_ALL;
            r_y_max <= '0;
            r_count <= '0;
        end else if (w_fg) begin
            if (r_x_cnt < r_x_min) r_x_min <= r_x_cnt;
            if (r_x_cnt > r_x_max) r_x_max <= r_x_cnt;
            if (r_y_cnt < r_y_min) r_y_min <= r_y_cnt;
            if (r_y_cnt > r_y_max) r_y_max <= r_y_cnt;
            if (r_count != c_CNT_ALL) r_count <= r_count + CNT_W'(1);
        end
    end

    // Frames below the pixel threshold report a zero box but the true count.
    always_ff @(posedge pixelclk) begin
        if (rst) begin
            r_out_x_min <= '0;
            r_out_x_max <= '0;
            r_out_y_min <= '0;
            r_out_y_max <= '0;
            r_out_cnt   <= '0;
            r_out_found <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (r_state == c_ST_LATCH) begin
                r_out_valid <= 1'b1;
                r_out_cnt   <= r_count;
                r_out_found <= w_found;
                if (w_found) begin
                    r_out_x_min <= r_x_min;
                    r_out_x_max <= r_x_max;
                    r_out_y_min <= r_y_min;
                    r_out_y_max <= r_y_max;
                end else begin
                    r_out_x_min <= '0;
                    r_out_x_max <= '0;
                    r_out_y_min <= '0;
                    r_out_y_max <= '0;
                end
            end
        end
    end

    assign bus.o_x_min   = r_out_x_min;
    assign bus.o_x_max   = r_out_x_max;
    assign bus.o_y_min   = r_out_y_min;
    assign bus.o_y_max   = r_out_y_max;
    assign bus.o_pix_cnt = r_out_cnt;
    assign bus.o_found   = r_out_found;
    assign bus.o_valid   = r_out_valid;

endmodule
`default_nettype wire

// File: doc/binary_bbox_stat.md
Name: binary_bbox_stat

Overview:
- Sits directly downstream of the binary-area pass-through stage and consumes its post_frame_vsync/href/clken/img_Bit stream.
- Per frame, computes the foreground bounding box (x/y min/max) and foreground pixel count.
- At each frame boundary, latches the results and pulses a valid strobe for the fruit classifier / overlay logic.
- Stream inputs are observed only; the block does not modify or re-emit the stream.

Parameters:
- H_W, 11, width of column counter and x outputs
- V_W, 11, width of row counter and y outputs
- CNT_W, 21, width of foreground pixel counter (saturating)
- MIN_PIXELS, 64, minimum foreground count for a frame to report found=1

Ports:
- pixelclk  in  1  pixel clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- i_vsync  in  1  frame sync; high = vertical blanking, rising edge = frame boundary
- i_href  in  1  line valid; falling edge = end of line
- i_clken  in  1  pixel valid (data enable)
- i_bit  in  1  binary pixel, 1 = foreground
- o_x_min  out  H_W  leftmost foreground column of last completed frame
- o_x_max  out  H_W  rightmost foreground column
- o_y_min  out  V_W  topmost foreground row
- o_y_max  out  V_W  bottommost foreground row
- o_pix_cnt  out  CNT_W  foreground pixel count of last frame
- o_found  out  1  1 if o_pix_cnt >= MIN_PIXELS
- o_valid  out  1  one-cycle pulse when outputs update

Behaviour:
- Clock/reset: one clock, pixelclk; reset is synchronous and active-high (rst).
- Reset values:
  - all outputs 0
  - internal min registers all-ones; max registers 0
  - x_cnt, y_cnt, count cleared
  - FSM to WAIT_FRAME
- Edge detection: registered copies of i_vsync and i_href.
  - vs_rise = i_vsync & ~vs_d
  - line_end = ~i_href & href_d
- FSM states:
  - WAIT_FRAME: ignore pixels until the first vs_rise; then clear accumulators and go to ACTIVE.
    - A partial frame after reset is never reported.
  - ACTIVE: accumulate.
    - On vs_rise go to LATCH; accumulators are not cleared in this same cycle.
  - LATCH: single cycle.
    - Copy accumulators to outputs and assert o_valid.
    - Clear accumulators and go to ACTIVE.
    - Pixels with i_clken=1 in this cycle are dropped; legal because i_vsync is high (blanking).
- Counters (ACTIVE only):
  - x_cnt increments on each i_clken.
  - On line_end: x_cnt cleared; y_cnt increments only if the line contained >=1 i_clken.
  - Both cleared on vs_rise.
  - x_cnt/y_cnt saturate at all-ones; no wrap.
- Accumulation: when i_clken & i_bit in ACTIVE, using the current x_cnt/y_cnt (pre-increment):
  - x_min = min(x_min, x_cnt)
  - x_max = max(x_max, x_cnt)
  - y_min = min(y_min, y_cnt)
  - y_max = max(y_max, y_cnt)
  - count += 1, saturating at 2^CNT_W-1
- Simultaneous line_end and i_clken in the same cycle: the pixel uses the old x_cnt, then x_cnt clears.
- Latch rules:
  - If count >= MIN_PIXELS: o_found=1 and box outputs take the accumulated values.
  - Otherwise: o_found=0 and o_x_min/o_x_max/o_y_min/o_y_max = 0; o_pix_cnt still reports the true count.
  - Outputs hold until the next LATCH.
- Latency: o_valid asserts 2 cycles after the i_vsync rising sample (1 edge-detect register + LATCH state).
- Reset mid-frame: all state cleared in the next cycle; o_valid never asserts for the interrupted frame; the block returns to WAIT_FRAME.
- Empty frame (no foreground): o_valid still pulses, with o_found=0 and o_pix_cnt=0.
- vsync held high across many cycles: only the rising edge triggers a latch; no repeated o_valid.

Decomposition:
- Shared package (isp_pkg): H_W/V_W defaults and FSM state encoding (WAIT_FRAME=2'd0, ACTIVE=2'd1, LATCH=2'd2).
- One natural sub-module, sync_edge_det: registers a sync signal and outputs rise/fall pulses; instantiated once for i_vsync and once for i_href.
- Min/max/count datapath stays in the top module.

Test Plan:
- Reset then 8x6 frame with foreground at (2..5, 1..3), MIN_PIXELS=4 -> at next vs_rise, o_valid pulse 2 cycles later; x_min=2, x_max=5, y_min=1, y_max=3, pix_cnt=12, found=1.
- All-zero frame -> o_valid pulse; found=0, pix_cnt=0, box outputs 0.
- Frame with 3 foreground pixels, MIN_PIXELS=4 -> found=0, box outputs 0, pix_cnt=3.
- Stream starts mid-frame after reset (no vs_rise yet) with foreground -> no o_valid until the second vs_rise; the first report covers only the full frame.
- Assert rst for 1 cycle mid-frame, then resume -> outputs 0 next cycle, no o_valid for that frame; the following complete frame reports correctly.
- Two consecutive frames with different boxes, (0,0)-(7,5) then (3,2)-(4,2) -> second report x_min=3, x_max=4, y_min=y_max=2 (accumulators cleared between frames); single-pixel line and i_clken coincident with line_end verified.
